ec_diff_inv: RTL and testbench

Inverse (deconvolution) filter for the `ec_diff` difference equation. It recovers the original stream x[n] from y[n] and is bit-exact against the forward block's N-bit modulo arithmetic and truncating shifts. It sits at the receive end of the filtered channel. It also serves as a loopback checker for the forward filter. It is a 2-stage pipeline with a valid qualifier, so samples may arrive with gaps.

---
 rtl/ec_diff_inv_pkg.sv | 11 +
 rtl/ec_diff_inv_hist.sv | 28 ++
 rtl/ec_diff_inv.sv | 84 ++++++++
 tb/tb_ec_diff_inv.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ec_diff_inv_pkg.sv
// Shared constants for the ec_diff inverse filter.
// The shift amounts must track the forward ec_diff block exactly.
package ec_diff_inv_pkg;

  localparam int unsigned Y1_SHIFT = 1;
  localparam int unsigned Y2_SHIFT = 2;

  localparam int unsigned Y_HIST_DEPTH = 2;
  localparam int unsigned X_HIST_DEPTH = 3;

endpackage

// File: rtl/ec_diff_inv_hist.sv
// Enable-gated tap-delay line: taps[0] is the newest sample, taps[D-1] the oldest.
// Clears asynchronously on rst and synchronously on clr.
module ec_diff_inv_hist #(
  parameter int unsigned N = 16,
  parameter int unsigned D = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [N-1:0]      d,
  output logic [D-1:0][N-1:0] taps
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (clr) begin
      taps <= '0;
    end else if (en) begin
      taps[0] <= d;
      for (int unsigned i = 1; i < D; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/ec_diff_inv.sv
// Inverse of the ec_diff difference equation: recovers x[n] from y[n] with
// N-bit wrapping arithmetic, in a 2-stage valid-qualified pipeline.
module ec_diff_inv
  import ec_diff_inv_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_valid,
  input  logic [N-1:0] i_y,
  output logic         o_valid,
  output logic [N-1:0] o_x
);

  logic [Y_HIST_DEPTH-1:0][N-1:0] y_hist;
  logic [X_HIST_DEPTH-1:0][N-1:0] x_hist;
  logic [N-1:0] a;
  logic [N-1:0] a_next;
  logic [N-1:0] x_next;
  logic         v1;

  // Logical shifts on the stored patterns reproduce the forward block's truncation.
  always_comb begin
    a_next = i_y - (y_hist[0] >> Y1_SHIFT) - (y_hist[1] >> Y2_SHIFT);
    x_next = a + x_hist[0] - x_hist[1] - x_hist[2];
  end

  ec_diff_inv_hist #(
    .N (N),
    .D (Y_HIST_DEPTH)
  ) u_y_hist (
    .clk  (clk),
    .rst  (i_rst),
    .clr  (i_clr),
    .en   (i_valid),
    .d    (i_y),
    .taps (y_hist)
  );

  ec_diff_inv_hist #(
    .N (N),
    .D (X_HIST_DEPTH)
  ) u_x_hist (
    .clk  (clk),
    .rst  (i_rst),
    .clr  (i_clr),
    .en   (v1),
    .d    (x_next),
    .taps (x_hist)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      a  <= '0;
      v1 <= 1'b0;
    end else if (i_clr) begin
      a  <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= i_valid;
      if (i_valid) begin
        a <= a_next;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_x     <= '0;
      o_valid <= 1'b0;
    end else if (i_clr) begin
      o_x     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= v1;
      if (v1) begin
        o_x <= x_next;
      end
    end
  end

endmodule

// File: tb/tb_ec_diff_inv.sv
// Scoreboard bench for ec_diff_inv: directed vectors, a forward-equation
// loopback, and a negedge monitor that pops expected samples on o_valid.
module tb_ec_diff_inv;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clr = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_y = '0;
  logic        o_valid;
  logic [15:0] o_x;

  ec_diff_inv #(.N(16)) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_clr   (i_clr),
    .i_valid (i_valid),
    .i_y     (i_y),
    .o_valid (o_valid),
    .o_x     (o_x)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_in = 0;
  int n_out = 0;
  bit hold_chk = 1'b0;
  logic [15:0] last_x = '0;
  logic [15:0] exp_q[$];

  // forward-model state
  logic [15:0] fx1 = '0, fx2 = '0, fx3 = '0, fy1 = '0, fy2 = '0;

  function automatic logic [15:0] fwd(input logic [15:0] x);
    logic [15:0] y;
    y = x - fx1 + fx2 + fx3 + (fy1 >> 1) + (fy2 >> 2);
    fx3 = fx2; fx2 = fx1; fx1 = x;
    fy2 = fy1; fy1 = y;
    return y;
  endfunction

  task automatic model_reset();
    fx1 = '0; fx2 = '0; fx3 = '0; fy1 = '0; fy2 = '0;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got o_valid=1 o_x=0x%04h, expected no output at %0t", o_x, $time);
        end else begin
          check("o_x", o_x, exp_q.pop_front());
        end
        last_x = o_x;
      end else if (hold_chk) begin
        check("o_x_hold", o_x, last_x);
      end
    end
  end

  task automatic send(input logic [15:0] y, input logic [15:0] x_exp);
    exp_q.push_back(x_exp);
    n_in++;
    i_valid = 1'b1;
    i_y = y;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear();
    i_clr = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0;
    model_reset();
  endtask

  initial begin
    #12;
    check("reset_valid", {15'd0, o_valid}, 16'h0000);
    check("reset_x", o_x, 16'h0000);
    @(posedge clk); #1;
    i_rst = 1'b0;
    idle(2);

    // impulse, back-to-back; y3 = 0x0000 recovers x3 = 0x8000
    send(16'h0001, 16'h0001);
    check("latency_early", {15'd0, o_valid}, 16'h0000);
    send(16'hFFFF, 16'h0000);
    check("latency_2cyc", {15'd0, o_valid}, 16'h0001);
    send(16'h8000, 16'h0000);
    send(16'h0000, 16'h8000);
    idle(4);

    // asynchronous reset mid-cycle with a sample in flight
    i_valid = 1'b1;
    i_y = 16'h0001;
    @(posedge clk); #1;
    i_valid = 1'b0;
    #3;
    i_rst = 1'b1;
    #1;
    check("async_rst_valid", {15'd0, o_valid}, 16'h0000);
    check("async_rst_x", o_x, 16'h0000);
    @(posedge clk); #1;
    i_rst = 1'b0;
    model_reset();
    idle(3);
    send(16'h0001, 16'h0001);
    send(16'hFFFF, 16'h0000);
    send(16'h8000, 16'h0000);
    send(16'h0000, 16'h8000);
    idle(4);

    // clear colliding with a valid sample: sample dropped, state zeroed
    i_clr = 1'b1;
    i_valid = 1'b1;
    i_y = 16'h1234;
    @(posedge clk); #1;
    i_clr = 1'b0;
    i_valid = 1'b0;
    model_reset();
    idle(4);
    send(16'h0005, 16'h0005);
    idle(4);

    // gap invariance: 3 idle cycles between samples, o_x must hold
    clear();
    send(16'h0001, 16'h0001);
    idle(2);
    hold_chk = 1'b1;
    idle(1);
    send(16'hFFFF, 16'h0000);
    idle(3);
    send(16'h8000, 16'h0000);
    idle(3);
    send(16'h0000, 16'h8000);
    idle(4);
    hold_chk = 1'b0;

    // wrap-around: constant 0xFFFF through the forward model
    clear();
    for (int i = 0; i < 20; i++) begin
      send(fwd(16'hFFFF), 16'hFFFF);
    end
    idle(4);

    // loopback with ~30% gaps
    clear();
    n_in = 0;
    n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] x;
      x = 16'($urandom);
      if ($urandom_range(99) < 30) idle(1);
      send(fwd(x), x);
    end
    idle(4);
    checks++;
    if (n_out != n_in) begin
      errors++;
      $display("FAIL loopback_count: got %0d outputs, expected %0d", n_out, n_in);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected samples, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
